// File: rtl/ov5640_pkg.sv
// rtl/ov5640_pkg.sv - shared enums and bar colours for the OV5640 DVP test-pattern source
package ov5640_pkg;

    typedef enum logic [1:0] {
        PAT_BARS  = 2'd0,
        PAT_GRAD  = 2'd1,
        PAT_WHITE = 2'd2,
        PAT_CHECK = 2'd3
    } pattern_t;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_VSYNC  = 3'd1,
        ST_VBP    = 3'd2,
        ST_ACTIVE = 3'd3,
        ST_VFP    = 3'd4
    } state_t;

    localparam logic [15:0] BAR_WHITE   = 16'hFFFF;
    localparam logic [15:0] BAR_YELLOW  = 16'hFFE0;
    localparam logic [15:0] BAR_CYAN    = 16'h07FF;
    localparam logic [15:0] BAR_GREEN   = 16'h07E0;
    localparam logic [15:0] BAR_MAGENTA = 16'hF81F;
    localparam logic [15:0] BAR_RED     = 16'hF800;
    localparam logic [15:0] BAR_BLUE    = 16'h001F;
    localparam logic [15:0] BAR_BLACK   = 16'h0000;

    function automatic logic [15:0] bar_color(input logic [2:0] idx);
        case (idx)
            3'd0:    return BAR_WHITE;
            3'd1:    return BAR_YELLOW;
            3'd2:    return BAR_CYAN;
            3'd3:    return BAR_GREEN;
            3'd4:    return BAR_MAGENTA;
            3'd5:    return BAR_RED;
            3'd6:    return BAR_BLUE;
            default: return BAR_BLACK;
        endcase
    endfunction

endpackage

// File: rtl/ov5640_pattern_pix.sv
// rtl/ov5640_pattern_pix.sv - RGB565 pixel value for a given column, line, bar and pattern
module ov5640_pattern_pix
    import ov5640_pkg::*;
(
    input  logic [8:0]  x,
    input  logic [8:0]  y,
    input  logic [2:0]  bar,
    input  pattern_t    pattern,
    output logic [15:0] pix
);

    logic unused_bits;
    assign unused_bits = ^{x[3:0], y[2:0]};

    always_comb begin
        pix = 16'h0000;
        unique case (pattern)
            PAT_BARS:  pix = bar_color(bar);
            PAT_GRAD:  pix = {x[8:4], y[8:3], x[8:4]};
            PAT_WHITE: pix = 16'hFFFF;
            PAT_CHECK: pix = (x[5] ^ y[5]) ? 16'hFFFF : 16'h0000;
        endcase
    end

endmodule

// File: rtl/ov5640_dvp_tx.sv
// rtl/ov5640_dvp_tx.sv - DVP frame timing, FSM and RGB565 byte serialiser
module ov5640_dvp_tx
    import ov5640_pkg::*;
#(
    parameter int H_PIXEL   = 640,
    parameter int V_PIXEL   = 480,
    parameter int H_BLANK   = 288,
    parameter int VS_LINES  = 4,
    parameter int VBP_LINES = 18,
    parameter int VFP_LINES = 8
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic       enable,
    input  logic [1:0] pattern_sel,
    output logic       dvp_vsync,
    output logic       dvp_href,
    output logic [7:0] dvp_data,
    output logic       frame_done,
    output logic       busy
);

    localparam int L_CYC  = 2 * H_PIXEL + H_BLANK;
    localparam int LCW    = $clog2(L_CYC);
    localparam int XW     = $clog2(H_PIXEL);
    localparam int BAR_W  = H_PIXEL / 8;
    localparam int BCW    = $clog2(BAR_W + 1);
    localparam int MAX_A  = (V_PIXEL > VS_LINES) ? V_PIXEL : VS_LINES;
    localparam int MAX_B  = (VBP_LINES > VFP_LINES) ? VBP_LINES : VFP_LINES;
    localparam int MAX_LN = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int LNW    = $clog2(MAX_LN + 1);

    localparam logic [LCW-1:0] L_LAST   = LCW'(L_CYC - 1);
    localparam logic [LCW-1:0] HREF_END = LCW'(2 * H_PIXEL);
    localparam logic [XW-1:0]  X_LAST   = XW'(H_PIXEL - 1);
    localparam logic [BCW-1:0] BAR_LAST = BCW'(BAR_W - 1);
    localparam logic [LNW-1:0] Y_LAST   = LNW'(V_PIXEL - 1);

    state_t         state;
    pattern_t       pat;
    logic [LCW-1:0] lcnt;
    logic [LNW-1:0] line_cnt;
    logic [XW-1:0]  x_cnt;
    logic [BCW-1:0] bar_cnt;
    logic [2:0]     bar_idx;
    logic           phase;

    logic [LNW-1:0] line_last;
    logic           line_end, seg_end, href_now;
    logic [15:0]    pix;

    // In ACTIVE the line counter doubles as the y coordinate.
    always_comb begin
        line_last = '0;
        case (state)
            ST_VSYNC:  line_last = LNW'(VS_LINES - 1);
            ST_VBP:    line_last = LNW'(VBP_LINES - 1);
            ST_ACTIVE: line_last = Y_LAST;
            ST_VFP:    line_last = LNW'(VFP_LINES - 1);
            default:   line_last = '0;
        endcase
    end

    assign line_end = (lcnt == L_LAST);
    assign seg_end  = line_end && (line_cnt == line_last);
    assign href_now = (state == ST_ACTIVE) && (lcnt < HREF_END);

    ov5640_pattern_pix u_pix (
        .x       (9'(x_cnt)),
        .y       (9'(line_cnt)),
        .bar     (bar_idx),
        .pattern (pat),
        .pix     (pix)
    );

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state      <= ST_IDLE;
            pat        <= PAT_BARS;
            lcnt       <= '0;
            line_cnt   <= '0;
            x_cnt      <= '0;
            bar_cnt    <= '0;
            bar_idx    <= '0;
            phase      <= 1'b0;
            dvp_vsync  <= 1'b0;
            dvp_href   <= 1'b0;
            dvp_data   <= 8'h00;
            frame_done <= 1'b0;
            busy       <= 1'b0;
        end else begin
            // Outputs trail the state/counters by one cycle, uniformly.
            dvp_vsync  <= (state == ST_VSYNC);
            dvp_href   <= href_now;
            dvp_data   <= href_now ? (phase ? pix[7:0] : pix[15:8]) : 8'h00;
            frame_done <= (state == ST_ACTIVE) && (line_cnt == Y_LAST) && (lcnt == HREF_END);
            busy       <= (state != ST_IDLE);

            if (state == ST_IDLE) begin
                if (enable) begin
                    state <= ST_VSYNC;
                    pat   <= pattern_t'(pattern_sel);
                end
            end else begin
                lcnt <= line_end ? '0 : lcnt + LCW'(1);
                if (line_end)
                    line_cnt <= seg_end ? '0 : line_cnt + LNW'(1);
                if (seg_end) begin
                    case (state)
                        ST_VSYNC:  state <= ST_VBP;
                        ST_VBP:    state <= ST_ACTIVE;
                        ST_ACTIVE: state <= ST_VFP;
                        default: begin
                            if (enable) begin
                                state <= ST_VSYNC;
                                pat   <= pattern_t'(pattern_sel);
                            end else begin
                                state <= ST_IDLE;
                            end
                        end
                    endcase
                end
            end

            if (href_now) begin
                phase <= ~phase;
                if (phase) begin
                    if (x_cnt == X_LAST) begin
                        x_cnt   <= '0;
                        bar_cnt <= '0;
                        bar_idx <= '0;
                    end else begin
                        x_cnt <= x_cnt + XW'(1);
                        if (bar_cnt == BAR_LAST) begin
                            bar_cnt <= '0;
                            bar_idx <= bar_idx + 3'd1;
                        end else begin
                            bar_cnt <= bar_cnt + BCW'(1);
                        end
                    end
                end
            end
        end
    end

endmodule
